// File: rtl/cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_serial_adder
//
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock. The block
// does not add anything itself. It feeds an external combinational 4-bit
// carry-lookahead adder one nibble per cycle, and collects that adder's sum
// and carry-out back into a W-bit result. The carry is held in a register
// between nibbles.
//
// Operation:
//   IDLE : in_ready=1. A valid operand set is latched, and the carry register
//          is loaded with in_cin.
//   RUN  : NIBBLES cycles, LSB nibble first. Each cycle one nibble pair plus
//          the running carry goes to the external adder, and its result is
//          stored.
//   DONE : out_valid=1 until out_ready is seen. Then the block returns to
//          IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set (IDLE, one edge after reset)
//   in_a/in_b  W-bit operands
//   in_cin     carry into nibble 0
//   add_a      nibble of a presented to the external CLA (0 outside RUN)
//   add_b      nibble of b presented to the external CLA (0 outside RUN)
//   add_cin    carry presented to the external CLA (0 outside RUN)
//   add_sum    4-bit sum returned by the external CLA (same cycle)
//   add_cout   carry out returned by the external CLA (same cycle)
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts the result
//   out_sum    assembled W-bit sum
//   out_cout   carry out of the MSB nibble
//   out_ovf    two's-complement overflow of the signed sum
// -----------------------------------------------------------------------------
module cla_nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result;
  // Cleared by reset and set on the first clock edge after it. It keeps
  // in_ready low until the block has seen a clean edge out of reset.
  logic          armed;
  logic          accept;
  logic          running;

  // Selects nibble i of a W-bit word. {i,2'b00} equals 4*i without a
  // multiplier.
  function automatic logic [3:0] nib_sel(input logic [W-1:0] v,
                                         input logic [IW-1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // Signed overflow: both operands have the same sign and the result sign
  // differs. Any carry-in is already folded into the result.
  function automatic logic ovf_flag(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign in_ready = (state == IDLE) && armed;
  assign accept   = in_valid && in_ready;
  assign running  = (state == RUN);

  // ---- Stage boundary: latch operands (IDLE), iterate nibbles (RUN), hold (DONE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= add_sum;
          carry                     <= add_cout;
          // idx stops at the last nibble, so it never wraps during an
          // operation.
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- Stage boundary: drive the external CLA and the result port
  assign add_a   = running ? nib_sel(a_reg, idx) : 4'h0;
  assign add_b   = running ? nib_sel(b_reg, idx) : 4'h0;
  assign add_cin = running ? carry : 1'b0;

  // The output flags follow the registers directly. They are meaningful
  // only while out_valid is high, and they read 0 while reset is active
  // because every source register is cleared.
  assign out_valid = (state == DONE);
  assign out_sum   = result;
  assign out_cout  = carry;
  assign out_ovf   = ovf_flag(a_reg[W-1], b_reg[W-1], result[W-1]);

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_serial_adder
//
// Testbench for cla_nibble_serial_adder with NIBBLES=4. A behavioural 4-bit
// adder stands in for the external CLA. A transaction-level reference model
// is checked every cycle, and directed vectors are checked against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_cla_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // External combinational 4-bit adder
  logic [4:0] cla_full;
  assign cla_full = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign add_sum  = cla_full[3:0];
  assign add_cout = cla_full[4];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int up_edges = 0;
  int n_done = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           acc;
  } op_t;

  op_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, written as plain arithmetic on whole operands
  function automatic logic [W:0] full_sum(input op_t o);
    return (W+1)'(o.a) + (W+1)'(o.b) + (W+1)'(o.cin);
  endfunction

  function automatic logic ref_ovf(input op_t o);
    int s;
    s = int'($signed(o.a)) + int'($signed(o.b)) + int'(o.cin);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [3:0] ref_nib(input logic [W-1:0] v, input int j);
    logic [31:0] t;
    t = 32'(v) >> (4 * j);
    return t[3:0];
  endfunction

  function automatic logic ref_carry_in(input op_t o, input int j);
    logic [31:0] m;
    logic [31:0] s;
    m = (32'd1 << (4 * j)) - 32'd1;
    s = ((32'(o.a) & m) + (32'(o.b) & m) + 32'(o.cin)) >> (4 * j);
    return s[0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) up_edges <= up_edges + 1;
    else       up_edges <= 0;
  end

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin : mon
    logic       exp_valid;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    logic [W:0] fs;
    int         j;
    op_t        o;
    if (!rst_n) begin
      check("reset_outputs",
            {out_valid, in_ready, add_a, add_b, add_cin, out_cout, out_ovf, out_sum}, 32'd0);
      q.delete();
    end else begin
      exp_valid = 1'b0;
      ea = 4'h0;
      eb = 4'h0;
      ec = 1'b0;
      if (q.size() > 0) begin
        j = cyc - q[0].acc;
        if (j >= 0 && j < N) begin
          ea = ref_nib(q[0].a, j);
          eb = ref_nib(q[0].b, j);
          ec = ref_carry_in(q[0], j);
        end
        exp_valid = (j >= N);
      end
      check("in_ready", in_ready, (up_edges >= 1) && (q.size() == 0));
      check("out_valid", out_valid, exp_valid);
      check("add_bus", {add_a, add_b, add_cin}, {ea, eb, ec});
      if (out_valid && q.size() > 0) begin
        fs = full_sum(q[0]);
        check("out_sum", out_sum, fs[W-1:0]);
        check("out_cout", out_cout, fs[W]);
        check("out_ovf", out_ovf, ref_ovf(q[0]));
        if (out_ready) begin
          void'(q.pop_front());
          n_done++;
        end
      end
      if (in_valid && in_ready) begin
        o.a = in_a;
        o.b = in_b;
        o.cin = in_cin;
        o.acc = cyc + 1;
        q.push_back(o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Full directed operation, called at posedge+1 with the block idle
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int stall, input logic [W-1:0] es, input logic ec,
                        input logic eo, output logic [3:0] cins);
    int k;
    int t0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    t0 = cyc;
    cins = 4'h0;
    k = 0;
    while (!out_valid && k < 20) begin
      if (k < 4) cins[k] = add_cin;
      tick();
      k++;
    end
    check("latency", cyc - t0, 4);
    check("dir_sum", out_sum, es);
    check("dir_cout", out_cout, ec);
    check("dir_ovf", out_ovf, eo);
    repeat (stall) begin
      tick();
      check("stall_hold", {out_valid, in_ready, out_sum}, {1'b1, 1'b0, es});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("done_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cins;
    int k;
    int t1;
    int t2;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    check("rdy_before_edge", in_ready, 0);
    tick();
    check("rdy_after_edge", in_ready, 1);

    // Carry through every nibble
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, cins);
    // Positive overflow and the per-nibble carry sequence
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, cins);
    check("cin_seq", cins, 4'b1110);
    // Carry-in with a stalled downstream
    run_op(16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0, 1'b0, cins);

    // Reset during the 2nd RUN cycle discards the operation
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_run",
          {out_valid, in_ready, add_a, add_b, add_cin, out_cout, out_ovf, out_sum}, 32'd0);
    tick();
    rst_n = 1'b1;
    check("rdy_low_after_rst", in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("discarded_op", out_valid, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, cins);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0; in_valid = 1'b1;
    check("b2b_ready", in_ready, 1);
    tick();
    t1 = cyc;
    in_a = 16'h00FF; in_b = 16'h0001;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("b2b1_sum", {out_sum, out_cout, out_ovf}, {16'h0000, 1'b1, 1'b1});
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    tick();
    t2 = cyc;
    in_valid = 1'b0;
    check("b2b_gap", t2 - t1, 6);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("b2b2_sum", {out_sum, out_cout, out_ovf}, {16'h0100, 1'b0, 1'b0});
    tick();
    out_ready = 1'b0;

    // Random operands with random downstream stalls
    base = n_done;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_cin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin tick(); k++; end
      check("rand_accept", in_ready, 1);
      if (!in_ready) begin
        in_valid = 1'b0;
        break;
      end
      tick();
      in_valid = 1'b0;
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 50) begin tick(); k++; end
    tick();
    check("rand_results", n_done - base, 1000);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_nibble_serial_adder.md
CLA_NIBBLE_SERIAL_ADDER -- requirements
Module: cla_nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set is valid.
REQ-005 Port: in_ready  output  1  block accepts an operand set.
REQ-006 Port: in_a  input  W  first operand.
REQ-007 Port: in_b  input  W  second operand.
REQ-008 Port: in_cin  input  1  carry into nibble 0.
REQ-009 Port: add_a  output  4  current nibble of operand a, to the external 4-bit CLA.
REQ-010 Port: add_b  output  4  current nibble of operand b, to the external 4-bit CLA.
REQ-011 Port: add_cin  output  1  carry into the external 4-bit CLA.
REQ-012 Port: add_sum  input  4  sum from the external CLA, combinational in the same cycle.
REQ-013 Port: add_cout  input  1  carry out from the external CLA, same cycle.
REQ-014 Port: out_valid  output  1  result is valid.
REQ-015 Port: out_ready  input  1  downstream accepts the result.
REQ-016 Port: out_sum  output  W  assembled W-bit sum.
REQ-017 Port: out_cout  output  1  carry out of the MSB nibble.
REQ-018 Port: out_ovf  output  1  two's-complement overflow flag.

Function
REQ-019 FSM states: IDLE, RUN, DONE; the nibble index idx is ceil(log2(NIBBLES)) bits wide.
REQ-020 IDLE: in_ready=1; on a clock edge with in_valid=1, latch in_a, in_b and in_cin, set carry register to in_cin, set idx=0, and go to RUN.
REQ-021 in_ready is 0 in RUN and DONE; in_valid in those states is ignored, and the latched operands do not change.
REQ-022 RUN: add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_cin = carry register.
REQ-023 RUN, each edge: result[4*idx+3:4*idx] <= add_sum; carry <= add_cout; idx <= idx+1.
REQ-024 RUN with idx=NIBBLES-1: on that edge, also go to DONE (no wrap of idx within an operation).
REQ-025 Outside RUN, add_a, add_b and add_cin are all 0.
REQ-026 Latency: out_valid rises exactly NIBBLES clock edges after the accepting edge; exactly NIBBLES RUN cycles per operation.
REQ-027 DONE: out_valid=1, out_sum=result, out_cout=carry register, out_ovf=(a_reg[W-1]==b_reg[W-1]) && (result[W-1]!=a_reg[W-1]).
REQ-028 DONE with out_ready=0: state and all outputs hold stable indefinitely.
REQ-029 DONE with out_ready=1: on the next edge, go to IDLE with out_valid=0; a new operand set can be accepted one edge later (in_ready rises in IDLE).
REQ-030 out_sum, out_cout and out_ovf hold their last values in IDLE and RUN until overwritten; they are meaningful only while out_valid=1.
REQ-031 Width rule: out_sum is the exact value (in_a + in_b + in_cin) mod 2^W; out_cout is bit W of the full sum.

Reset
REQ-032 rst_n=0, at any time including mid-RUN or in DONE: FSM goes immediately to IDLE, and idx, carry, a_reg, b_reg and result are cleared to 0.
REQ-033 During reset: out_valid=0, in_ready=0, add_a/add_b/add_cin=0, out_sum=0, out_cout=0, out_ovf=0.
REQ-034 in_ready rises on the first edge after rst_n deasserts; an operation in progress when reset asserted is discarded and produces no output.

Verification (NIBBLES=4, external 4-bit CLA attached)
REQ-035 in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_valid 4 edges after accept; out_sum=0x0000, out_cout=1, out_ovf=0.
REQ-036 in_a=0x7FFF, in_b=0x0001, in_cin=0 -> out_sum=0x8000, out_cout=0, out_ovf=1; add_cin observed as 0,1,1,1 over the RUN cycles.
REQ-037 in_a=0x1234, in_b=0x4321, in_cin=1, out_ready held 0 for 5 cycles -> out_sum=0x5556 held stable, in_ready=0 throughout; one-cycle out_ready=1 -> IDLE.
REQ-038 rst_n pulsed low during the 2nd RUN cycle -> out_valid never asserts for that operation; all outputs are 0 during reset; the next operation 0x0001+0x0001 -> out_sum=0x0002.
REQ-039 Back-to-back: in_valid held 1 with operands 0x8000+0x8000, then 0x00FF+0x0001, out_ready=1 -> results 0x0000/cout=1/ovf=1, then 0x0100/cout=0/ovf=0; accepting edges 6 edges apart.
REQ-040 Random: 1000 random operand sets with random out_ready stalls -> every result equals the reference sum mod 2^16, carry and overflow; no result is lost or duplicated.
